// File: rtl/hwag_pkg.sv
// hwag_pkg: shared angle-generator constants and channel state encoding.
package hwag_pkg;
    localparam int ANGLE_WIDTH = 24;
    localparam int ANGLE_TOP = 3839;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        ACTIVE = 2'd2
    } state_t;
endpackage

// File: rtl/hwag_angle_shadow.sv
// hwag_angle_shadow: double-buffered set/reset angles and channel enable.
module hwag_angle_shadow #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_ena,
    input  logic [W-1:0] wr_set,
    input  logic [W-1:0] wr_reset,
    input  logic         wr_ch_ena,
    input  logic         apply_ok,
    output logic [W-1:0] act_set,
    output logic [W-1:0] act_reset,
    output logic         act_ch_ena,
    output logic         pending
);
    logic [W-1:0] sh_set, sh_reset;
    logic sh_ch_ena, take;
    assign take = pending & apply_ok;
    // a write coinciding with apply keeps pending so the newer shadow is not lost
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_set     <= '0;
            sh_reset   <= '0;
            sh_ch_ena  <= 1'b0;
            act_set    <= '0;
            act_reset  <= '0;
            act_ch_ena <= 1'b0;
            pending    <= 1'b0;
        end else begin
            if (wr_ena) begin
                sh_set    <= wr_set;
                sh_reset  <= wr_reset;
                sh_ch_ena <= wr_ch_ena;
            end
            if (take) begin
                act_set    <= sh_set;
                act_reset  <= sh_reset;
                act_ch_ena <= sh_ch_ena;
            end
            pending <= wr_ena | (pending & ~take);
        end
    end
endmodule

// File: rtl/hwag_angle_channel.sv
// hwag_angle_channel: angle-triggered pulse output with deferred angle update
// and a clock-based maximum-dwell cutoff.
module hwag_angle_channel #(
    parameter int ANGLE_WIDTH = hwag_pkg::ANGLE_WIDTH,
    parameter logic [ANGLE_WIDTH-1:0] ANGLE_TOP = ANGLE_WIDTH'(hwag_pkg::ANGLE_TOP),
    parameter int DWELL_WIDTH = 24,
    parameter logic [DWELL_WIDTH-1:0] DWELL_MAX = DWELL_WIDTH'(4000000)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   hwag_start,
    input  logic [ANGLE_WIDTH-1:0] acnt,
    input  logic                   wr_ena,
    input  logic [ANGLE_WIDTH-1:0] wr_set,
    input  logic [ANGLE_WIDTH-1:0] wr_reset,
    input  logic                   wr_ch_ena,
    output logic                   out,
    output logic                   pending,
    output logic                   dwell_fault,
    input  logic                   fault_clr
);
    import hwag_pkg::*;
    localparam logic [DWELL_WIDTH-1:0] DWELL_LAST = DWELL_MAX - 1'b1;
    state_t state, state_nx;
    logic [ANGLE_WIDTH-1:0] acnt_prev, act_set, act_reset;
    logic [DWELL_WIDTH-1:0] dwell;
    logic act_ch_ena, step, wrap, hit_set, hit_reset, dwell_hit, cutoff, apply_ok;
    assign step      = hwag_start && acnt != acnt_prev;
    assign wrap      = step && acnt_prev == ANGLE_TOP && acnt == '0;
    assign hit_set   = step && acnt == act_set;
    assign hit_reset = step && acnt == act_reset;
    assign dwell_hit = dwell == DWELL_LAST;
    assign apply_ok  = state == IDLE || (wrap && state == ARMED);
    assign cutoff    = state == ACTIVE && hwag_start && !hit_reset && dwell_hit;
    assign out       = state == ACTIVE;
    hwag_angle_shadow #(.W(ANGLE_WIDTH)) u_shadow (
        .clk(clk),
        .rst(rst),
        .wr_ena(wr_ena),
        .wr_set(wr_set),
        .wr_reset(wr_reset),
        .wr_ch_ena(wr_ch_ena),
        .apply_ok(apply_ok),
        .act_set(act_set),
        .act_reset(act_reset),
        .act_ch_ena(act_ch_ena),
        .pending(pending)
    );
    // ACTIVE ignores ch_ena so a disable never truncates a running pulse
    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE:    state_nx = hwag_start && act_ch_ena ? ARMED : IDLE;
            ARMED:   state_nx = hit_set ? ACTIVE : (!hwag_start || !act_ch_ena) ? IDLE : ARMED;
            ACTIVE:  state_nx = !hwag_start ? IDLE : (hit_reset || dwell_hit) ? ARMED : ACTIVE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            acnt_prev   <= '0;
            dwell       <= '0;
            dwell_fault <= 1'b0;
        end else begin
            state       <= state_nx;
            acnt_prev   <= acnt;
            dwell       <= state != ACTIVE ? '0 : &dwell ? dwell : dwell + 1'b1;
            dwell_fault <= cutoff | (dwell_fault & ~fault_clr);
        end
    end
endmodule

// File: tb/tb_hwag_angle_channel.sv
// tb_hwag_angle_channel: directed scenarios plus random traffic on two channels
// (default and 100-cycle dwell) checked against a behavioural model.
module tb_hwag_angle_channel;
    localparam int TOP = 3839;
    localparam int S_IDLE = 0, S_ARMED = 1, S_ACTIVE = 2;
    logic clk = 1'b0, rst = 1'b0, hwag_start = 1'b0;
    logic wr_ena = 1'b0, wr_ch_ena = 1'b0, fault_clr = 1'b0;
    logic [23:0] acnt = '0, wr_set = '0, wr_reset = '0;
    logic out0, pend0, flt0, out1, pend1, flt1;
    int checks = 0, passed = 0;
    int dmax[2] = '{4000000, 100};
    int m_st[2], m_dw[2], m_flt[2], m_pend[2], m_prev[2];
    int m_sset[2], m_sres[2], m_sena[2], m_aset[2], m_ares[2], m_aena[2];

    always #5 clk = ~clk;

    hwag_angle_channel dut0 (
        .clk(clk), .rst(rst), .hwag_start(hwag_start), .acnt(acnt),
        .wr_ena(wr_ena), .wr_set(wr_set), .wr_reset(wr_reset), .wr_ch_ena(wr_ch_ena),
        .out(out0), .pending(pend0), .dwell_fault(flt0), .fault_clr(fault_clr)
    );
    hwag_angle_channel #(.DWELL_MAX(24'd100)) dut1 (
        .clk(clk), .rst(rst), .hwag_start(hwag_start), .acnt(acnt),
        .wr_ena(wr_ena), .wr_set(wr_set), .wr_reset(wr_reset), .wr_ch_ena(wr_ch_ena),
        .out(out1), .pending(pend1), .dwell_fault(flt1), .fault_clr(fault_clr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_st[i] = S_IDLE; m_dw[i] = 0; m_flt[i] = 0; m_pend[i] = 0; m_prev[i] = 0;
            m_sset[i] = 0; m_sres[i] = 0; m_sena[i] = 0;
            m_aset[i] = 0; m_ares[i] = 0; m_aena[i] = 0;
        end
    endtask

    // one clock of the channel rules, evaluated on the inputs present at the edge
    task automatic model_edge();
        int a;
        bit stp, wrp, hs, hr, app, cut;
        a = int'(acnt);
        for (int i = 0; i < 2; i++) begin
            stp = hwag_start && a != m_prev[i];
            wrp = stp && m_prev[i] == TOP && a == 0;
            hs  = stp && a == m_aset[i];
            hr  = stp && a == m_ares[i];
            app = m_pend[i] != 0 && (m_st[i] == S_IDLE || (wrp && m_st[i] == S_ARMED));
            cut = 0;
            if (m_st[i] == S_IDLE) begin
                if (hwag_start && m_aena[i] != 0) m_st[i] = S_ARMED;
            end else if (m_st[i] == S_ARMED) begin
                if (hs) begin
                    m_st[i] = S_ACTIVE;
                    m_dw[i] = 0;
                end else if (!hwag_start || m_aena[i] == 0) m_st[i] = S_IDLE;
            end else begin
                if (!hwag_start) m_st[i] = S_IDLE;
                else if (hr) m_st[i] = S_ARMED;
                else if (m_dw[i] == dmax[i] - 1) begin
                    m_st[i] = S_ARMED;
                    cut = 1;
                end else m_dw[i]++;
            end
            if (cut) m_flt[i] = 1;
            else if (fault_clr) m_flt[i] = 0;
            if (app) begin
                m_aset[i] = m_sset[i]; m_ares[i] = m_sres[i]; m_aena[i] = m_sena[i];
                m_pend[i] = 0;
            end
            if (wr_ena) begin
                m_sset[i] = int'(wr_set); m_sres[i] = int'(wr_reset); m_sena[i] = int'(wr_ch_ena);
                m_pend[i] = 1;
            end
            m_prev[i] = a;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_reset();
        else model_edge();
        #1;
        check("out0", out0, m_st[0] == S_ACTIVE);
        check("pending0", pend0, m_pend[0] != 0);
        check("fault0", flt0, m_flt[0] != 0);
        check("out1", out1, m_st[1] == S_ACTIVE);
        check("pending1", pend1, m_pend[1] != 0);
        check("fault1", flt1, m_flt[1] != 0);
        wr_ena = 1'b0;
        fault_clr = 1'b0;
    endtask

    task automatic next_angle();
        acnt = (int'(acnt) == TOP) ? '0 : acnt + 24'd1;
    endtask

    task automatic run(input int steps, input int per);
        repeat (steps) begin
            repeat (per) tick();
            next_angle();
        end
    endtask

    task automatic run_to(input int target, input int per);
        while (int'(acnt) != target) begin
            repeat (per) tick();
            next_angle();
        end
    endtask

    task automatic write(input int s, input int r, input bit e);
        wr_set = 24'(s);
        wr_reset = 24'(r);
        wr_ch_ena = e;
        wr_ena = 1'b1;
        tick();
    endtask

    function automatic int rand_angle();
        return ($urandom_range(0, 19) == 0) ? 3840 + int'($urandom_range(0, 100)) : int'($urandom_range(0, TOP));
    endfunction

    initial begin
        int s;
        model_reset();
        repeat (3) tick();
        rst = 1'b1;
        tick();
        // basic pulse, one angle step per 4 clocks
        hwag_start = 1'b1;
        write(128, 640, 1'b1);
        run_to(300, 4);
        run(3840, 4);
        // deferred apply while the 128/640 pulse is high
        check("defer_out_high", out0, 1);
        write(1000, 1200, 1'b1);
        check("defer_pending", pend0, 1);
        run_to(1300, 1);
        // wrap-spanning pulse
        write(3800, 50, 1'b1);
        run_to(100, 1);
        run_to(3820, 1);
        check("span_out_high", out0, 1);
        // generator loss
        hwag_start = 1'b0;
        tick();
        check("loss_out0", out0, 0);
        check("loss_out1", out1, 0);
        write(128, 640, 1'b1);
        repeat (3) tick();
        hwag_start = 1'b1;
        run_to(130, 1);
        check("rearm_out0", out0, 1);
        // dwell cutoff with the angle frozen at 130
        repeat (150) tick();
        check("dwell_out0", out0, 1);
        check("dwell_out1", out1, 0);
        check("dwell_fault1", flt1, 1);
        check("dwell_fault0", flt0, 0);
        fault_clr = 1'b1;
        tick();
        check("fault_clr1", flt1, 0);
        // asynchronous reset mid-pulse
        write(1000, 1200, 1'b1);
        check("pre_rst_pending", pend0, 1);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("rst_out0", out0, 0);
        check("rst_out1", out1, 0);
        check("rst_pending0", pend0, 0);
        check("rst_fault1", flt1, 0);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        // random traffic
        write(int'($urandom_range(0, TOP)), int'($urandom_range(0, TOP)), 1'b1);
        repeat (15000) begin
            if ($urandom_range(0, 199) == 0) begin
                s = rand_angle();
                wr_set = 24'(s);
                wr_reset = ($urandom_range(0, 9) == 0) ? 24'(s) : 24'(rand_angle());
                wr_ch_ena = ($urandom_range(0, 7) != 0);
                wr_ena = 1'b1;
            end
            if ($urandom_range(0, 299) == 0) fault_clr = 1'b1;
            if (hwag_start && $urandom_range(0, 999) < 3) hwag_start = 1'b0;
            else if (!hwag_start && $urandom_range(0, 19) == 0) hwag_start = 1'b1;
            s = int'($urandom_range(0, 99));
            if (s < 85) next_angle();
            else if (s == 85) acnt = 24'($urandom_range(0, TOP));
            tick();
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
